// File: rtl/sync_debounce.sv
// Multi-channel level synchroniser with a per-channel debounce filter.
// Optional rise/fall event pulses are enabled by defining SYNC_DEBOUNCE_EDGE_EN.
module sync_debounce #(
  parameter int unsigned      Width          = 4,
  parameter int unsigned      Stages         = 2,
  parameter logic [Width-1:0] ResetValue     = '0,
  parameter int unsigned      DebounceCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [Width-1:0] serial_i,
  output logic [Width-1:0] serial_o
`ifdef SYNC_DEBOUNCE_EDGE_EN
  ,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
`endif
);

  logic             w_init;
  logic [Width-1:0] r_sync [Stages];
  logic [Width-1:0] w_filt;

  // Reset and clear share one path; reset simply wins by being OR-ed in.
  assign w_init = ~rst_ni | clr_i;

  // Synchroniser shift chain, every stage reloaded with ResetValue on init.
  always_ff @(posedge clk_i) begin
    if (w_init) begin
      for (int k = 0; k < Stages; k++) begin
        r_sync[k] <= ResetValue;
      end
    end else begin
      r_sync[0] <= serial_i;
      for (int k = 1; k < Stages; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  generate
    if (DebounceCycles == 0) begin : g_bypass
      assign w_filt = r_sync[Stages-1];
    end else begin : g_filter
      localparam int unsigned    CntW    = $clog2(DebounceCycles + 1);
      localparam logic [CntW-1:0] CntTerm = CntW'(DebounceCycles - 1);

      logic [CntW-1:0]  r_cnt     [Width];
      logic [CntW-1:0]  w_cnt_nxt [Width];
      logic [Width-1:0] r_filt;
      logic [Width-1:0] w_filt_nxt;

      // Per-channel stability counter; accepts the new level on terminal count.
      always_comb begin
        w_cnt_nxt  = r_cnt;
        w_filt_nxt = r_filt;
        for (int i = 0; i < Width; i++) begin
          if (r_sync[Stages-1][i] == r_filt[i]) begin
            w_cnt_nxt[i] = '0;
          end else if (r_cnt[i] == CntTerm) begin
            w_filt_nxt[i] = r_sync[Stages-1][i];
            w_cnt_nxt[i]  = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CntW'(1);
          end
        end
      end

      // Filter state registers; init discards any partial count.
      always_ff @(posedge clk_i) begin
        if (w_init) begin
          r_filt <= ResetValue;
          for (int i = 0; i < Width; i++) begin
            r_cnt[i] <= '0;
          end
        end else begin
          r_filt <= w_filt_nxt;
          r_cnt  <= w_cnt_nxt;
        end
      end

      assign w_filt = r_filt;
    end
  endgenerate

  assign serial_o = w_filt;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic [Width-1:0] r_filt_d;

  // Delayed copy of the output; reloading it with ResetValue suppresses init pulses.
  always_ff @(posedge clk_i) begin
    if (w_init) begin
      r_filt_d <= ResetValue;
    end else begin
      r_filt_d <= w_filt;
    end
  end

  assign rise_o = w_filt & ~r_filt_d;
  assign fall_o = ~w_filt & r_filt_d;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboarded bench for sync_debounce: a debounced instance (Stages=2, D=4) and a bypass instance (Stages=3, D=0).
module tb_sync_debounce;
  localparam logic [3:0] RV = 4'b0101;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       clr_i;
  logic [3:0] serial_i;
  logic [3:0] serial_o;
  logic [3:0] byp_o;
`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic [3:0] rise_o, fall_o, byp_rise, byp_fall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_debounce #(.Width(4), .Stages(2), .ResetValue(RV), .DebounceCycles(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .serial_i(serial_i), .serial_o(serial_o)
`ifdef SYNC_DEBOUNCE_EDGE_EN
    , .rise_o(rise_o), .fall_o(fall_o)
`endif
  );

  sync_debounce #(.Width(4), .Stages(3), .ResetValue(RV), .DebounceCycles(0)) u_byp (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .serial_i(serial_i), .serial_o(byp_o)
`ifdef SYNC_DEBOUNCE_EDGE_EN
    , .rise_o(byp_rise), .fall_o(byp_fall)
`endif
  );

  typedef struct packed {
    logic [3:0] so, ri, fa, bso, bri, bfa;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: window of synchronised samples since the last init.
  logic [3:0] m_pipe [2];
  logic [3:0] m_hist [$];
  logic [3:0] m_f, m_fd;
  logic [3:0] b_pipe [3];
  logic [3:0] b_fd;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      chk("serial_o", serial_o, e.so);
      chk("byp_serial_o", byp_o, e.bso);
`ifdef SYNC_DEBOUNCE_EDGE_EN
      chk("rise_o", rise_o, e.ri);
      chk("fall_o", fall_o, e.fa);
      chk("byp_rise_o", byp_rise, e.bri);
      chk("byp_fall_o", byp_fall, e.bfa);
`endif
    end
  endtask

  task automatic step(input logic [3:0] din, input logic rn, input logic clr);
    logic [3:0] s_old, flip;
    bit         all_diff;
    exp_t       e;
    serial_i = din;
    rst_ni   = rn;
    clr_i    = clr;
    @(posedge clk);
    if (!rn || clr) begin
      m_pipe[0] = RV; m_pipe[1] = RV;
      m_f = RV; m_fd = RV;
      m_hist.delete();
      b_pipe[0] = RV; b_pipe[1] = RV; b_pipe[2] = RV;
      b_fd = RV;
    end else begin
      m_fd  = m_f;
      s_old = m_pipe[1];
      m_hist.push_back(s_old);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      flip = 4'b0000;
      if (m_hist.size() == 4) begin
        for (int ch = 0; ch < 4; ch++) begin
          all_diff = 1'b1;
          for (int j = 0; j < 4; j++) begin
            if (m_hist[j][ch] == m_f[ch]) all_diff = 1'b0;
          end
          flip[ch] = all_diff;
        end
      end
      m_f = m_f ^ flip;
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = din;
      b_fd = b_pipe[2];
      b_pipe[2] = b_pipe[1];
      b_pipe[1] = b_pipe[0];
      b_pipe[0] = din;
    end
    e.so  = m_f;       e.ri  = m_f & ~m_fd;       e.fa  = ~m_f & m_fd;
    e.bso = b_pipe[2]; e.bri = b_pipe[2] & ~b_fd; e.bfa = ~b_pipe[2] & b_fd;
    sb_q.push_back(e);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    int r3, f3;
    logic [3:0] din;
    serial_i = 4'hF; rst_ni = 1'b0; clr_i = 1'b0;
    @(negedge clk);

    // Reset held three edges with inputs opposite to ResetValue.
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b0, 1'b0);
      chk("reset_hold", serial_o, RV);
    end
    step(4'hF, 1'b1, 1'b0);
    chk("reset_release", serial_o, RV);
    for (int i = 0; i < 10; i++) step(RV, 1'b1, 1'b0);

    // Clean step on channel 1: visible after the sixth sampling edge.
    for (int i = 0; i < 6; i++) begin
      step(4'b0111, 1'b1, 1'b0);
      if (i == 4) chk("step_before", serial_o, 4'b0101);
    end
    chk("step_after", serial_o, 4'b0111);
`ifdef SYNC_DEBOUNCE_EDGE_EN
    chk("step_rise", rise_o, 4'b0010);
`endif
    step(4'b0111, 1'b1, 1'b0);
`ifdef SYNC_DEBOUNCE_EDGE_EN
    chk("step_rise_once", rise_o, 4'b0000);
`endif
    for (int i = 0; i < 4; i++) step(4'b0111, 1'b1, 1'b0);

    // Glitches on channel 3: three edges is rejected, four is accepted.
    r3 = 0; f3 = 0;
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(4'b0111, 1'b1, 1'b0);
      chk("glitch3_low", {3'b000, serial_o[3]}, 4'b0000);
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1, 1'b0);
`ifdef SYNC_DEBOUNCE_EDGE_EN
      r3 += int'(rise_o[3]); f3 += int'(fall_o[3]);
`endif
    end
    for (int i = 0; i < 12; i++) begin
      step(4'b0111, 1'b1, 1'b0);
`ifdef SYNC_DEBOUNCE_EDGE_EN
      r3 += int'(rise_o[3]); f3 += int'(fall_o[3]);
`endif
    end
`ifdef SYNC_DEBOUNCE_EDGE_EN
    chk("glitch4_rise_count", 4'(r3), 4'd1);
    chk("glitch4_fall_count", 4'(f3), 4'd1);
`endif

    // Reset dropped between edges must wait for the next edge.
    rst_ni = 1'b0;
    #1;
    chk("reset_sync_only", serial_o, 4'b0111);
    step(4'b0111, 1'b0, 1'b0);
    chk("reset_applied", serial_o, RV);
    for (int i = 0; i < 8; i++) step(RV, 1'b1, 1'b0);

    // Clear while channel 1 is mid-count, then full latency again.
    for (int i = 0; i < 4; i++) step(4'b0111, 1'b1, 1'b0);
    step(4'b0111, 1'b1, 1'b1);
    chk("clear_value", serial_o, RV);
    for (int i = 0; i < 6; i++) begin
      step(4'b0111, 1'b1, 1'b0);
      if (i == 4) chk("clear_relatency_before", serial_o, RV);
    end
    chk("clear_relatency_after", serial_o, 4'b0111);

    // Simultaneous rise on channel 1 and fall on channel 0.
    for (int i = 0; i < 10; i++) step(RV, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0110, 1'b1, 1'b0);
    chk("simul_serial", serial_o, 4'b0110);
`ifdef SYNC_DEBOUNCE_EDGE_EN
    chk("simul_rise", rise_o, 4'b0010);
    chk("simul_fall", fall_o, 4'b0001);
`endif

    // Fast toggling holds the last accepted value; bypass shows single-cycle pulses.
    for (int i = 0; i < 24; i++) step((i % 4 < 2) ? 4'b1001 : 4'b0110, 1'b1, 1'b0);
    chk("toggle_hold", serial_o, 4'b0110);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("byp_pulse", byp_o, 4'b1111);
    step(4'b0000, 1'b1, 1'b0);
    chk("byp_after_pulse", byp_o, 4'b0000);

    // Random slow-changing inputs with occasional clears.
    din = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) din[b] = ~din[b];
      end
      step(din, 1'b1, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
